patch_loader: RTL and testbench
===============================

PATCH_LOADER -- requirements
Module: patch_loader

Interface
REQ-001 SHALL have parameter inputSize, default 9, the signed sample width; tree sum width is inputSize+8.
REQ-002 SHALL have clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have in_valid  input  1  sample offered.
REQ-005 SHALL have in_ready  output  1  sample accepted when in_valid && in_ready at a clk edge.
REQ-006 SHALL have in_sof  input  1  qualified by in_valid; marks the first sample of a patch.
REQ-007 SHALL have in_data  input  inputSize  signed sample, row-major order, 16 per row.
REQ-008 SHALL have operand  output  [16][16] x inputSize  signed registered patch bank driving the adder tree.
REQ-009 SHALL have tree_enable  output  1  stage enable for the 8-stage registered adder tree.
REQ-010 SHALL have sum_in  input  inputSize+8  signed tree sum.
REQ-011 SHALL have out_valid, out_ready  output/input  1 each  result handshake.
REQ-012 SHALL have out_sum  output  inputSize+8  signed registered patch sum.

Function
REQ-013 SHALL run FSM LOAD -> COPY -> LOAD; reset state LOAD.
REQ-014 LOAD: in_ready=1; each accepted sample SHALL be written to shadow[idx/16][idx%16], and idx SHALL increment, wrapping 255->0.
REQ-015 An accepted sample with in_sof=1 SHALL be written at index 0 and set idx=1, discarding any partial patch.
REQ-016 Accepting the sample at index 255 SHALL move the FSM to COPY.
REQ-017 COPY: in_ready=0; bank SHALL load the full shadow in one edge, but only when the result slot is empty or is being drained (out_ready=1) that cycle; otherwise COPY holds.
REQ-018 The copy edge SHALL load lat_cnt=8 and return the FSM to LOAD.
REQ-019 tree_enable SHALL equal (lat_cnt!=0); lat_cnt SHALL decrement by 1 per cycle while nonzero.
REQ-020 On the edge after the one where lat_cnt goes 1->0, out_sum SHALL capture sum_in and out_valid SHALL set.
REQ-021 out_valid/out_sum SHALL hold until out_ready; a capture and a drain in the same edge SHALL leave the new result valid.
REQ-022 Latency: with out_ready=1, out_valid SHALL rise exactly 10 cycles after the edge that accepts the 255-index sample.
REQ-023 Because a patch load takes at least 256 cycles, at most one patch SHALL be in flight; no in-flight overlap handling is required.
REQ-024 The bank SHALL remain static except on copy edges; the shadow SHALL accept the next patch while the tree runs.
REQ-025 No arithmetic SHALL be performed in this block; sums SHALL pass through at full inputSize+8 width with no truncation.

Reset
REQ-026 On rst: FSM=LOAD, idx=0, lat_cnt=0, tree_enable=0, out_valid=0, out_sum=0, bank=0; shadow is not reset.
REQ-027 rst mid-load or mid-flight SHALL drop the partial patch and any in-flight result; no out_valid SHALL follow.

Structure
REQ-028 Package patch_pkg SHALL hold PATCH_DIM=16, PATCH_SAMPLES=256, TREE_LATENCY=8, and the FSM state enum.
REQ-029 The one-entry result slot (out_valid/out_sum/out_ready) SHALL be a sub-module patch_result_slot; counters and the FSM stay inline.

Verification
REQ-030 256 samples of +1, out_ready=1 -> out_sum=256; out_valid rises 10 cycles after the last accept; tree_enable high for exactly 8 cycles.
REQ-031 256 samples of -256 -> out_sum=-65536; 256 samples of +255 -> out_sum=65280 (width extremes).
REQ-032 out_ready=0, two patches streamed -> the second holds in COPY with in_ready=0 until out_ready=1; both sums are delivered in order.
REQ-033 in_sof reasserted at index 100 of a patch of 5s, then a fresh patch of 3s -> single out_sum=768.
REQ-034 rst asserted at index 128, and separately at lat_cnt=4 -> no out_valid; the next full patch of 1s -> out_sum=256.
REQ-035 Ramp patch: value = index mod 16 minus 8 -> out_sum=-128; bank row/column placement is checked against the shadow index.

Source files
------------

// File: rtl/patch_pkg.sv
// Shared constants and FSM state type for the patch loader and its result slot.
package patch_pkg;

    localparam int PATCH_DIM     = 16;
    localparam int PATCH_SAMPLES = PATCH_DIM * PATCH_DIM;
    localparam int TREE_LATENCY  = 8;
    localparam int IDX_W         = 8;
    localparam int LAT_W         = 4;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_COPY = 1'b1
    } state_e;

endpackage

// File: rtl/patch_loader_if.sv
// Sample-in and result-out handshakes of the patch loader.
interface patch_loader_if #(
    parameter int inputSize = 9
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic                          in_sof;
    logic signed [inputSize-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [inputSize+7:0]   out_sum;

    modport master (
        output in_valid, in_sof, in_data, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_sof, in_data, out_ready,
        output in_ready, out_valid, out_sum
    );

endinterface

// File: rtl/patch_result_slot.sv
// One-entry result holding register; a capture wins over a same-edge drain.
module patch_result_slot #(
    parameter int SUM_W = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture,
    input  logic signed [SUM_W-1:0] sum_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [SUM_W-1:0] out_sum,
    output logic                    slot_free
);

    logic                    valid_q, valid_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;

    always_comb begin
        valid_d = valid_q;
        sum_d   = sum_q;
        if (capture) begin
            valid_d = 1'b1;
            sum_d   = sum_in;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign slot_free = !valid_q || out_ready;

endmodule

// File: rtl/patch_loader.sv
// Streams 256 signed samples into a shadow buffer, copies them into the operand
// bank feeding an external 8-stage adder tree, and captures the tree sum.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_LOAD | accepting samples into the shadow buffer
// ST_COPY | full patch held; waiting for a free result slot to copy
module patch_loader
    import patch_pkg::*;
#(
    parameter int inputSize = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    patch_loader_if.slave                 bus,
    output logic signed [inputSize-1:0]   operand [PATCH_DIM][PATCH_DIM],
    output logic                          tree_enable,
    input  logic signed [inputSize+7:0]   sum_in
);

    localparam int SUM_W = inputSize + 8;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [LAT_W-1:0]            lat_cnt_q, lat_cnt_d;
    logic                        fire_q, fire_d;
    logic signed [inputSize-1:0] shadow_q [PATCH_SAMPLES];
    logic signed [inputSize-1:0] shadow_d [PATCH_SAMPLES];
    logic signed [inputSize-1:0] bank_q [PATCH_DIM][PATCH_DIM];
    logic signed [inputSize-1:0] bank_d [PATCH_DIM][PATCH_DIM];

    logic accept;
    logic copy_go;
    logic slot_free;

    assign bus.in_ready = (state_q == ST_LOAD);
    assign accept       = bus.in_valid && bus.in_ready;
    assign copy_go      = (state_q == ST_COPY) && slot_free;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        bank_d   = bank_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        // a new start-of-frame abandons any partial patch
                        shadow_d[0] = bus.in_data;
                        idx_d       = IDX_W'(1);
                    end else begin
                        shadow_d[idx_q] = bus.in_data;
                        idx_d           = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(PATCH_SAMPLES - 1)) begin
                            state_d = ST_COPY;
                        end
                    end
                end
            end
            ST_COPY: begin
                if (slot_free) begin
                    for (int r = 0; r < PATCH_DIM; r++) begin
                        for (int c = 0; c < PATCH_DIM; c++) begin
                            bank_d[r][c] = shadow_q[r*PATCH_DIM + c];
                        end
                    end
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // fire_q marks the cycle after the tree's last enabled stage
    always_comb begin
        lat_cnt_d = lat_cnt_q;
        fire_d    = (lat_cnt_q == LAT_W'(1));
        if (lat_cnt_q != '0) begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
        if (copy_go) begin
            lat_cnt_d = LAT_W'(TREE_LATENCY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            idx_q     <= '0;
            lat_cnt_q <= '0;
            fire_q    <= 1'b0;
            bank_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lat_cnt_q <= lat_cnt_d;
            fire_q    <= fire_d;
            bank_q    <= bank_d;
        end
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign operand     = bank_q;
    assign tree_enable = (lat_cnt_q != '0);

    patch_result_slot #(
        .SUM_W (SUM_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .capture   (fire_q),
        .sum_in    (sum_in),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_sum   (bus.out_sum),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_patch_loader.sv
// Directed bench for patch_loader with a behavioural 8-stage registered adder tree.
module tb_patch_loader;

    localparam int IS = 9;
    localparam int SW = IS + 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    patch_loader_if #(.inputSize(IS)) bus ();

    logic signed [IS-1:0] operand [16][16];
    logic                 tree_enable;
    logic signed [SW-1:0] sum_in;

    patch_loader #(.inputSize(IS)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .operand     (operand),
        .tree_enable (tree_enable),
        .sum_in      (sum_in)
    );

    // adder tree model: full sum of the bank, delayed by 8 enabled stages
    logic signed [SW-1:0] tree_in;
    logic signed [SW-1:0] pipe [8];

    always_comb begin
        tree_in = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                tree_in = tree_in + SW'(operand[r][c]);
    end

    initial for (int k = 0; k < 8; k++) pipe[k] = '0;

    always @(posedge clk) begin
        if (tree_enable) begin
            pipe[0] <= tree_in;
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign sum_in = pipe[7];

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic signed [SW-1:0] got [$];
    int   en_cnt   = 0;
    int   rise_cyc = 0;
    logic prev_v   = 1'b0;

    always @(negedge clk) begin
        if (tree_enable) en_cnt++;
        if (bus.out_valid && !prev_v) rise_cyc = cyc;
        prev_v = bus.out_valid;
        if (bus.out_valid && bus.out_ready && !rst) got.push_back(bus.out_sum);
    end

    int vectors    = 0;
    int miscompares = 0;
    int last_acc   = 0;
    logic signed [IS-1:0] pat [256];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sof, input logic signed [IS-1:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check("in_ready_timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 256; i++) pat[i] = IS'(v);
    endtask

    task automatic send_pat(input logic first_sof);
        for (int i = 0; i < 256; i++) push(first_sof && (i == 0), pat[i]);
        last_acc = cyc;
    endtask

    task automatic wait_results(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, got.size(), n);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_tree_enable", tree_enable, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_bank_00", operand[0][0], 0);
        check("rst_bank_ff", operand[15][15], 0);
        rst = 1'b0;
        tick();

        // all ones: sum, latency, tree enable duration
        got.delete(); en_cnt = 0;
        fill(1);
        send_pat(1'b1);
        wait_results("ones_count", 1, 40);
        if (got.size() > 0) check("ones_sum", got[0], 256);
        check("ones_latency", rise_cyc - last_acc, 10);
        check("ones_enable_cycles", en_cnt, 8);
        tick();
        check("ones_drained", bus.out_valid, 0);

        // width extremes
        got.delete();
        fill(-256);
        send_pat(1'b1);
        wait_results("neg_count", 1, 40);
        if (got.size() > 0) check("neg_sum", got[0], -65536);

        got.delete();
        fill(255);
        send_pat(1'b1);
        wait_results("pos_count", 1, 40);
        if (got.size() > 0) check("pos_sum", got[0], 65280);

        // ramp: placement in the bank
        got.delete();
        for (int i = 0; i < 256; i++) pat[i] = IS'((i % 16) - 8);
        send_pat(1'b1);
        wait_results("ramp_count", 1, 40);
        if (got.size() > 0) check("ramp_sum", got[0], -128);
        check("ramp_bank_3_5", operand[3][5], -3);
        check("ramp_bank_15_0", operand[15][0], -8);
        check("ramp_bank_0_15", operand[0][15], 7);
        check("ramp_bank_9_12", operand[9][12], 4);

        // back-pressure: second patch holds in COPY
        got.delete();
        bus.out_ready = 1'b0;
        fill(2);
        send_pat(1'b1);
        fill(1);
        send_pat(1'b1);
        repeat (5) tick();
        check("hold_in_ready", bus.in_ready, 0);
        check("hold_out_valid", bus.out_valid, 1);
        check("hold_out_sum", bus.out_sum, 512);
        check("hold_bank_static", operand[0][0], 2);
        check("hold_no_drain", got.size(), 0);
        bus.out_ready = 1'b1;
        wait_results("hold_count", 2, 40);
        if (got.size() > 1) begin
            check("hold_first", got[0], 512);
            check("hold_second", got[1], 256);
        end

        // sof restart mid-patch
        got.delete();
        for (int i = 0; i < 100; i++) push(i == 0, IS'(5));
        fill(3);
        send_pat(1'b1);
        wait_results("sof_count", 1, 40);
        if (got.size() > 0) check("sof_sum", got[0], 768);
        repeat (30) tick();
        check("sof_single", got.size(), 1);

        // reset in the middle of a load
        got.delete();
        for (int i = 0; i < 128; i++) push(i == 0, IS'(7));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fill(1);
        send_pat(1'b0);
        wait_results("rstload_count", 1, 40);
        if (got.size() > 0) check("rstload_sum", got[0], 256);
        repeat (30) tick();
        check("rstload_single", got.size(), 1);

        // reset while the tree is running
        got.delete();
        fill(9);
        send_pat(1'b1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("rstflight_none", got.size(), 0);
        check("rstflight_out_valid", bus.out_valid, 0);
        check("rstflight_tree_enable", tree_enable, 0);
        check("rstflight_bank", operand[0][0], 0);
        fill(1);
        send_pat(1'b1);
        wait_results("rstflight_count", 1, 40);
        if (got.size() > 0) check("rstflight_sum", got[0], 256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
